sram_stream_loader: RTL and testbench

//  Upstream loader for the conv accelerator's feature/kernel SRAM bank ports (fram_*/kram_* BRAM ctrl ports).

---
 rtl/sram_stream_loader_pkg.sv | 15 +
 rtl/sram_stream_loader.sv | 153 +++++++++++++++
 tb/tb_sram_stream_loader.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/sram_stream_loader_pkg.sv
// Shared types for the SRAM stream loader: FSM states and completion status codes.
package sram_stream_loader_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      DONE = 2'd2
   } loader_state_e;

   localparam logic [1:0] ST_OK     = 2'b00;  // all words written, tlast on the final word
   localparam logic [1:0] ST_EARLY  = 2'b01;  // tlast arrived before the final word
   localparam logic [1:0] ST_NOLAST = 2'b10;  // final word arrived without tlast
   localparam logic [1:0] ST_ALIGN  = 2'b11;  // base address not word aligned

endpackage

// File: rtl/sram_stream_loader.sv
// Loads an AXI-Stream of words into consecutive FRAM or KRAM word addresses, stalling while
// the accelerator runs, and reports completion with a one-cycle done pulse and a status code.
module sram_stream_loader
   import sram_stream_loader_pkg::*;
#(
   parameter int unsigned DATA_WIDTH   = 32,
   parameter int unsigned FRAM_BYTE_AW = 16,
   parameter int unsigned KRAM_BYTE_AW = 14,
   parameter int unsigned CNT_WIDTH    = 16
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    cmd_valid,
   output logic                    cmd_ready,
   input  logic                    cmd_target,
   input  logic [FRAM_BYTE_AW-1:0] cmd_base,
   input  logic [CNT_WIDTH-1:0]    cmd_words,
   input  logic                    acc_running,
   input  logic [DATA_WIDTH-1:0]   s_axis_tdata,
   input  logic                    s_axis_tvalid,
   output logic                    s_axis_tready,
   input  logic                    s_axis_tlast,
   output logic [FRAM_BYTE_AW-1:0] fram_addr_byteidx,
   output logic [DATA_WIDTH-1:0]   fram_wdata,
   output logic                    fram_en,
   output logic                    fram_we,
   output logic [KRAM_BYTE_AW-1:0] kram_addr_byteidx,
   output logic [DATA_WIDTH-1:0]   kram_wdata,
   output logic                    kram_en,
   output logic                    kram_we,
   output logic                    busy,
   output logic                    done,
   output logic [1:0]              status
);

   loader_state_e state_q, state_d;
   logic [1:0]              status_q, status_d;
   logic                    accept, beat;
   logic                    target_q;
   logic [FRAM_BYTE_AW-1:0] addr_q;
   logic [CNT_WIDTH-1:0]    words_q, idx_q;
   logic                    last_idx;

   assign last_idx = (idx_q == words_q - CNT_WIDTH'(1));
   assign busy     = (state_q == LOAD);
   assign done     = (state_q == DONE);
   assign status   = status_q;

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state, handshakes and completion status.
   always_comb begin
      state_d       = state_q;
      status_d      = status_q;
      cmd_ready     = 1'b0;
      s_axis_tready = 1'b0;
      accept        = 1'b0;
      beat          = 1'b0;
      unique case (state_q)
         IDLE: begin
            // Gated by rst so nothing is accepted during the reset cycle.
            cmd_ready = ~acc_running & ~rst;
            if (cmd_valid && cmd_ready) begin
               accept = 1'b1;
               if (cmd_base[1:0] != 2'b00) begin
                  state_d  = DONE;
                  status_d = ST_ALIGN;
               end else if (cmd_words == '0) begin
                  state_d  = DONE;
                  status_d = ST_OK;
               end else begin
                  state_d  = LOAD;
                  status_d = ST_OK;
               end
            end
         end
         LOAD: begin
            s_axis_tready = ~acc_running & ~rst;
            if (s_axis_tvalid && s_axis_tready) begin
               beat = 1'b1;
               if (last_idx) begin
                  state_d  = DONE;
                  status_d = s_axis_tlast ? ST_OK : ST_NOLAST;
               end else if (s_axis_tlast) begin
                  state_d  = DONE;
                  status_d = ST_EARLY;
               end
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Command latch, beat counter, running byte address and registered SRAM write port.
   always_ff @(posedge clk) begin
      if (rst) begin
         status_q          <= ST_OK;
         target_q          <= 1'b0;
         addr_q            <= '0;
         words_q           <= '0;
         idx_q             <= '0;
         fram_addr_byteidx <= '0;
         fram_wdata        <= '0;
         fram_en           <= 1'b0;
         fram_we           <= 1'b0;
         kram_addr_byteidx <= '0;
         kram_wdata        <= '0;
         kram_en           <= 1'b0;
         kram_we           <= 1'b0;
      end else begin
         status_q <= status_d;
         fram_en  <= 1'b0;
         fram_we  <= 1'b0;
         kram_en  <= 1'b0;
         kram_we  <= 1'b0;
         if (accept) begin
            target_q <= cmd_target;
            addr_q   <= cmd_base;
            words_q  <= cmd_words;
            idx_q    <= '0;
         end
         if (beat) begin
            idx_q  <= idx_q + CNT_WIDTH'(1);
            // Address wraps naturally at the port width.
            addr_q <= addr_q + FRAM_BYTE_AW'(4);
            if (target_q) begin
               kram_en           <= 1'b1;
               kram_we           <= 1'b1;
               kram_addr_byteidx <= addr_q[KRAM_BYTE_AW-1:0];
               kram_wdata        <= s_axis_tdata;
            end else begin
               fram_en           <= 1'b1;
               fram_we           <= 1'b1;
               fram_addr_byteidx <= addr_q;
               fram_wdata        <= s_axis_tdata;
            end
         end
      end
   end

endmodule

// File: tb/tb_sram_stream_loader.sv
// Self-checking bench for sram_stream_loader: directed table, hand-written reset/stall
// sequences and randomized commands checked against a transaction-level model.
module tb_sram_stream_loader;

   logic        clk = 1'b0;
   logic        rst;
   logic        cmd_valid, cmd_ready, cmd_target;
   logic [15:0] cmd_base, cmd_words;
   logic        acc_running;
   logic [31:0] s_axis_tdata;
   logic        s_axis_tvalid, s_axis_tready, s_axis_tlast;
   logic [15:0] fram_addr_byteidx;
   logic [31:0] fram_wdata;
   logic        fram_en, fram_we;
   logic [13:0] kram_addr_byteidx;
   logic [31:0] kram_wdata;
   logic        kram_en, kram_we;
   logic        busy, done;
   logic [1:0]  status;

   sram_stream_loader dut (
      .clk               (clk),
      .rst               (rst),
      .cmd_valid         (cmd_valid),
      .cmd_ready         (cmd_ready),
      .cmd_target        (cmd_target),
      .cmd_base          (cmd_base),
      .cmd_words         (cmd_words),
      .acc_running       (acc_running),
      .s_axis_tdata      (s_axis_tdata),
      .s_axis_tvalid     (s_axis_tvalid),
      .s_axis_tready     (s_axis_tready),
      .s_axis_tlast      (s_axis_tlast),
      .fram_addr_byteidx (fram_addr_byteidx),
      .fram_wdata        (fram_wdata),
      .fram_en           (fram_en),
      .fram_we           (fram_we),
      .kram_addr_byteidx (kram_addr_byteidx),
      .kram_wdata        (kram_wdata),
      .kram_en           (kram_en),
      .kram_we           (kram_we),
      .busy              (busy),
      .done              (done),
      .status            (status)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;
   int done_cnt = 0;
   int overlap_cnt = 0;
   int gate_viol = 0;
   logic [1:0] done_status = 2'b00;
   int unsigned wr_tgt[$];
   int unsigned wr_addr[$];
   int unsigned wr_data[$];
   int unsigned data[64];

   typedef struct {
      int tgt;
      int base;
      int words;
      int last_at;
      int exp_st;
      int exp_nwr;
   } vec_t;
   vec_t vecs[10];

   // Observe the SRAM ports, done pulses and acc_running gating mid-cycle.
   always @(negedge clk) begin
      if (fram_en && fram_we) begin
         wr_tgt.push_back(0);
         wr_addr.push_back(int'(fram_addr_byteidx));
         wr_data.push_back(fram_wdata);
      end
      if (kram_en && kram_we) begin
         wr_tgt.push_back(1);
         wr_addr.push_back(int'(kram_addr_byteidx));
         wr_data.push_back(kram_wdata);
      end
      if (done) begin
         done_cnt    <= done_cnt + 1;
         done_status <= status;
         if (busy) overlap_cnt <= overlap_cnt + 1;
      end
      if (acc_running && (s_axis_tready || cmd_ready)) gate_viol <= gate_viol + 1;
   end

   task automatic check(input string nm, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   task automatic issue_cmd(input int tgt, input int base, input int words, input bit hold);
      bit fired = 1'b0;
      int k = 0;
      cmd_valid   = 1'b1;
      cmd_target  = tgt[0];
      cmd_base    = base[15:0];
      cmd_words   = words[15:0];
      acc_running = hold;
      while (!fired && k < 50) begin
         @(negedge clk);
         fired = cmd_valid & cmd_ready;
         @(posedge clk);
         #1;
         k++;
         if (k >= 2) acc_running = 1'b0;
      end
      cmd_valid   = 1'b0;
      acc_running = 1'b0;
      check("cmd_accept", int'(fired), 1);
   endtask

   // Offers n beats from data[]; tlast on beat last_at. rnd adds tvalid gaps and acc stalls.
   task automatic stream(input int n, input int last_at, input bit rnd, output int taken);
      int cyc = 0;
      bit fire;
      taken = 0;
      while (taken < n && cyc < 400) begin
         acc_running   = rnd ? ($urandom_range(0, 3) == 0) : 1'b0;
         s_axis_tvalid = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
         s_axis_tdata  = data[taken];
         s_axis_tlast  = (taken == last_at);
         @(negedge clk);
         fire = s_axis_tvalid & s_axis_tready;
         @(posedge clk);
         #1;
         if (fire) taken++;
         cyc++;
      end
      s_axis_tvalid = 1'b0;
      s_axis_tlast  = 1'b0;
      acc_running   = 1'b0;
   endtask

   // One complete load, checked against the transaction model; exp_* < 0 means model only.
   task automatic run_cmd(input int tgt, input int base, input int words, input int last_at,
                          input bit rnd, input int exp_st, input int exp_nwr);
      int n, st, taken, cnt0, k, aw_mask, a;
      if ((base & 3) != 0) begin
         n = 0; st = 3;
      end else if (words == 0) begin
         n = 0; st = 0;
      end else if (last_at >= 0 && last_at < words - 1) begin
         n = last_at + 1; st = 1;
      end else if (last_at == words - 1) begin
         n = words; st = 0;
      end else begin
         n = words; st = 2;
      end
      for (int i = 0; i < 64; i++) data[i] = $urandom;
      wr_tgt.delete();
      wr_addr.delete();
      wr_data.delete();
      cnt0 = done_cnt;
      issue_cmd(tgt, base, words, rnd && ($urandom_range(0, 3) == 0));
      stream(n, last_at, rnd, taken);
      check("beats_taken", taken, n);
      k = 0;
      while (done_cnt == cnt0 && k < 20) begin
         @(posedge clk);
         #1;
         k++;
      end
      repeat (2) @(posedge clk);
      #1;
      check("done_pulses", done_cnt - cnt0, 1);
      check("done_status", int'(done_status), st);
      check("status_hold", int'(status), st);
      check("n_writes", wr_addr.size(), n);
      if (exp_st >= 0) check("tbl_status", int'(status), exp_st);
      if (exp_nwr >= 0) check("tbl_writes", wr_addr.size(), exp_nwr);
      aw_mask = (tgt != 0) ? 32'h3FFF : 32'hFFFF;
      for (int i = 0; i < n && i < wr_addr.size(); i++) begin
         a = ((base & aw_mask) + 4 * i) & aw_mask;
         check("wr_target", int'(wr_tgt[i]), tgt);
         check("wr_addr", int'(wr_addr[i]), a);
         check("wr_data", int'(wr_data[i]), int'(data[i]));
      end
   endtask

   initial begin
      int taken;
      int tgt, base, words, last_at;
      vecs[0] = '{0, 32'h0100, 4,  3, 0, 4};
      vecs[1] = '{1, 32'h0000, 3,  1, 1, 2};
      vecs[2] = '{0, 32'h0200, 2, -1, 2, 2};
      vecs[3] = '{0, 32'h0102, 4,  3, 3, 0};
      vecs[4] = '{0, 32'hFFFC, 2,  1, 0, 2};
      vecs[5] = '{1, 32'h3FF8, 3,  2, 0, 3};
      vecs[6] = '{0, 32'h0040, 0, -1, 0, 0};
      vecs[7] = '{1, 32'hC010, 2,  1, 0, 2};
      vecs[8] = '{1, 32'h0008, 1,  0, 0, 1};
      vecs[9] = '{0, 32'h0020, 5,  0, 1, 1};

      rst = 1'b1;
      cmd_valid = 1'b0; cmd_target = 1'b0; cmd_base = '0; cmd_words = '0;
      acc_running = 1'b0;
      s_axis_tdata = '0; s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
      cmd_valid = 1'b1;
      @(negedge clk);
      check("rst_cmd_ready", int'(cmd_ready), 0);
      repeat (2) @(posedge clk);
      #1;
      cmd_valid = 1'b0;
      rst = 1'b0;
      @(negedge clk);
      check("rst_outputs", int'({busy, done, status, fram_en, fram_we, kram_en, kram_we,
                                 s_axis_tready}), 0);
      check("rst_addr", int'({fram_addr_byteidx, kram_addr_byteidx}), 0);
      check("idle_cmd_ready", int'(cmd_ready), 1);
      @(posedge clk);
      #1;

      foreach (vecs[i])
         run_cmd(vecs[i].tgt, vecs[i].base, vecs[i].words, vecs[i].last_at, 1'b0,
                 vecs[i].exp_st, vecs[i].exp_nwr);

      // acc_running toggling with tvalid gaps over an 8-word load.
      run_cmd(0, 32'h1000, 8, 7, 1'b1, 0, 8);

      // Reset after 2 of 5 beats, then a normal load.
      for (int i = 0; i < 64; i++) data[i] = $urandom;
      wr_tgt.delete(); wr_addr.delete(); wr_data.delete();
      issue_cmd(0, 32'h0500, 5, 1'b0);
      stream(2, -1, 1'b0, taken);
      check("rst_beats", taken, 2);
      rst = 1'b1;
      @(negedge clk);
      check("rst_mid_ready", int'({cmd_ready, s_axis_tready}), 0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      check("rst_mid_outputs", int'({fram_en, fram_we, kram_en, kram_we, busy, done}), 0);
      check("rst_mid_nwr", wr_addr.size(), 2);
      if (wr_addr.size() == 2) begin
         check("rst_mid_addr0", int'(wr_addr[0]), 32'h0500);
         check("rst_mid_addr1", int'(wr_addr[1]), 32'h0504);
      end
      @(posedge clk);
      #1;
      run_cmd(1, 32'h0040, 3, 2, 1'b0, 0, 3);

      // Randomized commands against the model.
      for (int r = 0; r < 30; r++) begin
         tgt     = $urandom_range(0, 1);
         base    = $urandom_range(0, 65535);
         if ($urandom_range(0, 7) != 0) base = base & 32'hFFFC;
         words   = $urandom_range(0, 9);
         last_at = $urandom_range(0, words + 1) - 1;
         run_cmd(tgt, base, words, last_at, 1'b1, -1, -1);
      end

      check("busy_done_overlap", overlap_cnt, 0);
      check("acc_gating", gate_viol, 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
